img_edge_pad: RTL and testbench
===============================

# img_edge_pad

Restores full-size AXI4-Stream video frames by padding a cropped interior image with a constant-valued border. It is the inverse of the edge-cut stage. An interior stream of (IMG_WIDTH−2·PAD_COLUMN)×(IMG_HEIGHT−2·PAD_ROW) pixels enters, and an IMG_WIDTH×IMG_HEIGHT frame leaves with PAD_VALUE border rows and columns inserted. The block sits downstream of window or kernel stages that shrink the frame, and it uses full valid/ready handshakes on both sides.

## Interface
Parameters:
- PAD_COLUMN, 1: border columns inserted on each of the left and right sides; 0 allowed.
- PAD_ROW, 1: border rows inserted on each of the top and bottom; 0 allowed.
- DATA_WIDTH, 8: pixel width in bits; must be a multiple of 8.
- IMG_WIDTH, 640: output row length; must be ≤ 4095.
- IMG_HEIGHT, 480: output row count; must be ≤ 4095.
- PAD_VALUE, 0: DATA_WIDTH-bit border pixel value.

Ports:
- s_axis_aclk  in  1  the single clock.
- s_axis_aresetn  in  1  asynchronous, active-low reset.
- enable  in  1  1 = pad, 0 = bypass. Sampled only in IDLE.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted.
- s_axis_tdata  in  DATA_WIDTH  interior pixel.
- s_axis_tuser  in  1  start of frame, on the first interior pixel.
- s_axis_tlast  in  1  end of line. Ignored in pad mode; counters are authoritative.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_WIDTH  output pixel.
- m_axis_tuser  out  1  high on output pixel (0,0) only.
- m_axis_tlast  out  1  high on column IMG_WIDTH−1 of every row.
- m_axis_tkeep  out  DATA_WIDTH/8  all ones.

## Operation
- FSM states: IDLE, TOP, LEFT, BODY, RIGHT, BOTTOM.
- Counters: 12-bit col_cnt and row_cnt, both counting output positions. They advance only when a beat is loaded into the output register.
- **IDLE**
  - s_axis_tready=1 while s_axis_tuser=0, so stray beats are consumed and dropped.
  - s_axis_tvalid & s_axis_tuser: s_axis_tready=0, the beat is not consumed, enable is latched into mode_r, and the FSM goes to TOP. If PAD_ROW=0 it goes to LEFT; if PAD_COLUMN=0 as well, it goes to BODY.
- **TOP / BOTTOM**: emit PAD_VALUE for PAD_ROW full rows. s_axis_tready=0.
- **LEFT / RIGHT**: emit PAD_VALUE for PAD_COLUMN pixels. s_axis_tready=0.
- **BODY**
  - s_axis_tready = output register free (m_axis_tvalid=0 or m_axis_tready=1).
  - Each accepted beat is forwarded with its tdata.
  - Leaves after IMG_WIDTH−2·PAD_COLUMN accepted beats.
- Row sequencing:
  - After RIGHT, or after BODY when PAD_COLUMN=0: the next interior row goes to LEFT. After the last interior row it goes to BOTTOM, or to IDLE when PAD_ROW=0.
  - After the last BOTTOM pixel, go to IDLE.
- Output flags are generated from the counters, not copied from the input:
  - m_axis_tuser = (row_cnt==0 && col_cnt==0).
  - m_axis_tlast = (col_cnt==IMG_WIDTH−1).
- Input tuser seen in BODY other than on the first pixel: it is treated as data, no resync, and the flag is discarded.
- **Bypass** (mode_r=0): m_axis_* = s_axis_* combinationally and s_axis_tready = m_axis_tready. The output register is not used. The block returns to IDLE when an input tlast beat is accepted with col and row counters at the interior frame end. Simplified rule: bypass holds until the next s_axis_tuser after at least one tlast. enable changes mid-frame take effect only at the next IDLE.

## Timing
- Reset values: every output is 0 except m_axis_tkeep, which is all ones. FSM = IDLE, counters = 0, mode_r = 0.
- Reset asserted mid-frame: m_axis_tvalid drops asynchronously and the pending beat is lost. After release the block waits in IDLE for a new tuser.
- Pad mode uses one output register. An interior pixel accepted on cycle N is presented on cycle N+1.
- The first border pixel is presented 1 cycle after the IDLE→TOP transition.
- The IDLE→TOP decision takes 1 cycle, so frames are separated by at least 1 idle output cycle.
- Throughput is 1 beat/cycle with m_axis_tready=1 and s_axis_tvalid continuous. There are no bubbles at LEFT/BODY/RIGHT boundaries.
- While m_axis_tvalid=1 & m_axis_tready=0, m_axis_tdata, m_axis_tuser and m_axis_tlast hold stable.
- Bypass latency is 0 cycles.

## Structure
- Shared video package holds the FSM state encoding, the 12-bit counter width constant, and the derived constants IN_WIDTH=IMG_WIDTH−2·PAD_COLUMN and IN_HEIGHT=IMG_HEIGHT−2·PAD_ROW.
- Elaboration check: IN_WIDTH ≥ 1 and IN_HEIGHT ≥ 1.
- One sub-module, axis_out_reg: a single-entry valid/ready output register with a load/free interface, reusable by other video stages.

## Test plan
- IMG 6×4, PAD 1/1, PAD_VALUE=8'hFF, enable=1, input 4×2 pixels 1..8, m_axis_tready=1 → 24 beats. Rows 0 and 3 are all FF; row 1 = FF,1,2,3,4,FF; row 2 = FF,5,6,7,8,FF. tuser on beat 0 only; tlast on beats 5,11,17,23.
- Same config with m_axis_tready toggled randomly (50%) → identical beat sequence. Data is stable while stalled, and no input beat is accepted outside BODY.
- PAD_ROW=0, PAD_COLUMN=2, IMG 8×2 → each row = PAD,PAD, 4 interior, PAD,PAD. No border rows.
- Reset asserted mid-BODY of frame 1, then a full frame 2 → m_axis_tvalid=0 immediately. Frame 2 is output complete, with tuser on its first beat.
- enable=0 → output equals input beat-for-beat with 0 latency and tready mirrored. Toggling enable to 1 mid-frame does not change that frame; the next frame is padded.
- Three beats without tuser arrive before a tuser beat → all 3 are dropped, and padding starts from the tuser beat.

Source files
------------

// File: rtl/img_edge_pad_pkg.sv
// Shared constants and FSM encoding for the edge-pad video stage.
package img_edge_pad_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TOP,
    ST_LEFT,
    ST_BODY,
    ST_RIGHT,
    ST_BOTTOM
  } pad_state_e;

  // Interior extent of one axis once the border has been removed from both sides.
  function automatic int inner_dim(input int full, input int pad);
    return full - 2 * pad;
  endfunction

endpackage

// File: rtl/img_edge_pad_out_reg.sv
// Single-entry valid/ready output register with a load/free interface.
module axis_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_user,
  input  logic                  load_last,
  output logic                  free,
  output logic                  valid,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  user,
  output logic                  last
);

  assign free = !valid || ready;

  // The producer only loads when free, so a stalled beat is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      user  <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      user  <= load_user;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/img_edge_pad.sv
// Edge-pad stage: rebuilds a full IMG_WIDTH x IMG_HEIGHT frame from a cropped
// interior stream by inserting constant-valued border rows and columns.
//
// state     | meaning
// ST_IDLE   | drop stray beats, wait for a start-of-frame beat, latch enable
// ST_TOP    | emit PAD_ROW full border rows
// ST_LEFT   | emit PAD_COLUMN left border pixels
// ST_BODY   | forward interior pixels; in bypass, pass the whole frame through
// ST_RIGHT  | emit PAD_COLUMN right border pixels
// ST_BOTTOM | emit PAD_ROW full border rows
module img_edge_pad
  import img_edge_pad_pkg::*;
#(
  parameter int                    PAD_COLUMN = 1,
  parameter int                    PAD_ROW    = 1,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    IMG_WIDTH  = 640,
  parameter int                    IMG_HEIGHT = 480,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
  input  logic                    s_axis_aclk,
  input  logic                    s_axis_aresetn,
  input  logic                    enable,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep
);

  localparam int IN_WIDTH  = inner_dim(IMG_WIDTH, PAD_COLUMN);
  localparam int IN_HEIGHT = inner_dim(IMG_HEIGHT, PAD_ROW);

  localparam logic [CNT_W-1:0] LAST_COL     = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_ROW     = CNT_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] TOP_END_ROW  = CNT_W'(PAD_ROW - 1);
  localparam logic [CNT_W-1:0] LEFT_END_COL = CNT_W'(PAD_COLUMN - 1);
  localparam logic [CNT_W-1:0] BODY_END_COL = CNT_W'(IMG_WIDTH - PAD_COLUMN - 1);
  localparam logic [CNT_W-1:0] BODY_END_ROW = CNT_W'(IMG_HEIGHT - PAD_ROW - 1);

  localparam pad_state_e ROW_START_ST = (PAD_COLUMN > 0) ? ST_LEFT : ST_BODY;
  localparam pad_state_e FIRST_ST     = (PAD_ROW > 0) ? ST_TOP : ROW_START_ST;
  localparam pad_state_e AFTER_BODY_ST = (PAD_ROW > 0) ? ST_BOTTOM : ST_IDLE;

  generate
    if (IN_WIDTH < 1 || IN_HEIGHT < 1) begin : g_bad_interior
      $error("img_edge_pad: interior image must be at least 1x1");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("img_edge_pad: DATA_WIDTH must be a multiple of 8");
    end
    if (IMG_WIDTH > 4095 || IMG_HEIGHT > 4095) begin : g_bad_size
      $error("img_edge_pad: image dimensions must fit the 12-bit counters");
    end
  endgenerate

  pad_state_e             state_q, state_d;
  logic                   mode_r;
  logic                   seen_last_r;
  logic                   run_r;
  logic [CNT_W-1:0]       col_cnt, row_cnt;

  logic                   load;
  logic [DATA_WIDTH-1:0]  load_data;
  logic                   pad_tready;
  logic                   leave_idle;
  logic                   bypass;
  logic                   bypass_exit;

  logic                   reg_free, reg_valid, reg_user, reg_last;
  logic [DATA_WIDTH-1:0]  reg_data;

  assign bypass      = (state_q == ST_BODY) && !mode_r;
  // A new start-of-frame after a completed line closes the bypass frame; that
  // beat is held back so IDLE can decide how the next frame is handled.
  assign bypass_exit = bypass && seen_last_r && s_axis_tvalid && s_axis_tuser;

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    load_data  = PAD_VALUE;
    pad_tready = 1'b0;
    leave_idle = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pad_tready = run_r && !s_axis_tuser;
        // Bypass drives the output combinationally, so drain the register first.
        if (run_r && s_axis_tvalid && s_axis_tuser && (enable || !reg_valid)) begin
          leave_idle = 1'b1;
          state_d    = enable ? FIRST_ST : ST_BODY;
        end
      end
      ST_TOP: begin
        load = reg_free;
        if (reg_free && col_cnt == LAST_COL && row_cnt == TOP_END_ROW)
          state_d = ROW_START_ST;
      end
      ST_LEFT: begin
        load = reg_free;
        if (reg_free && col_cnt == LEFT_END_COL)
          state_d = ST_BODY;
      end
      ST_BODY: begin
        if (mode_r) begin
          pad_tready = reg_free;
          load       = reg_free && s_axis_tvalid;
          load_data  = s_axis_tdata;
          if (reg_free && s_axis_tvalid && col_cnt == BODY_END_COL) begin
            if (PAD_COLUMN > 0)
              state_d = ST_RIGHT;
            else if (row_cnt == BODY_END_ROW)
              state_d = AFTER_BODY_ST;
            else
              state_d = ROW_START_ST;
          end
        end else if (bypass_exit) begin
          state_d = ST_IDLE;
        end
      end
      ST_RIGHT: begin
        load = reg_free;
        if (reg_free && col_cnt == LAST_COL)
          state_d = (row_cnt == BODY_END_ROW) ? AFTER_BODY_ST : ROW_START_ST;
      end
      ST_BOTTOM: begin
        load = reg_free;
        if (reg_free && col_cnt == LAST_COL && row_cnt == LAST_ROW)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q     <= ST_IDLE;
      mode_r      <= 1'b0;
      seen_last_r <= 1'b0;
      run_r       <= 1'b0;
      col_cnt     <= '0;
      row_cnt     <= '0;
    end else begin
      state_q <= state_d;
      run_r   <= 1'b1;
      if (leave_idle) begin
        mode_r      <= enable;
        seen_last_r <= 1'b0;
      end else if (bypass && s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
        seen_last_r <= 1'b1;
      end
      if (load) begin
        if (col_cnt == LAST_COL) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + CNT_W'(1);
        end else begin
          col_cnt <= col_cnt + CNT_W'(1);
        end
      end
    end
  end

  axis_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk      (s_axis_aclk),
    .rst_n    (s_axis_aresetn),
    .load     (load),
    .load_data(load_data),
    .load_user(row_cnt == '0 && col_cnt == '0),
    .load_last(col_cnt == LAST_COL),
    .free     (reg_free),
    .valid    (reg_valid),
    .ready    (m_axis_tready),
    .data     (reg_data),
    .user     (reg_user),
    .last     (reg_last)
  );

  assign s_axis_tready = bypass ? (m_axis_tready && !bypass_exit) : pad_tready;
  assign m_axis_tvalid = bypass ? (s_axis_tvalid && !bypass_exit) : reg_valid;
  assign m_axis_tdata  = bypass ? s_axis_tdata : reg_data;
  assign m_axis_tuser  = bypass ? s_axis_tuser : reg_user;
  assign m_axis_tlast  = bypass ? s_axis_tlast : reg_last;
  assign m_axis_tkeep  = '1;

endmodule

// File: tb/tb_img_edge_pad.sv
// Randomized self-checking bench for img_edge_pad against a position-based frame model.
module tb_img_edge_pad;

  localparam int AW = 6, AH = 4, APC = 1, APR = 1;
  localparam logic [7:0] APAD = 8'hFF;
  localparam int BW = 8, BH = 2, BPC = 2, BPR = 0;
  localparam logic [7:0] BPAD = 8'h3C;

  typedef struct packed {
    logic [7:0] d;
    logic       u;
    logic       l;
    logic       b;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       enable, s_tvalid, s_tready, s_tuser, s_tlast, s_tbyp;
  logic [7:0] s_tdata, m_tdata;
  logic       m_tvalid, m_tready, m_tuser, m_tlast;
  logic [0:0] m_tkeep;

  logic       enable_b, sb_tvalid, sb_tready, sb_tuser, sb_tlast;
  logic [7:0] sb_tdata, mb_tdata;
  logic       mb_tvalid, mb_tready, mb_tuser, mb_tlast;
  logic [0:0] mb_tkeep;

  img_edge_pad #(.PAD_COLUMN(APC), .PAD_ROW(APR), .DATA_WIDTH(8),
                 .IMG_WIDTH(AW), .IMG_HEIGHT(AH), .PAD_VALUE(APAD)) dut_a (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .enable(enable),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast), .m_axis_tkeep(m_tkeep));

  img_edge_pad #(.PAD_COLUMN(BPC), .PAD_ROW(BPR), .DATA_WIDTH(8),
                 .IMG_WIDTH(BW), .IMG_HEIGHT(BH), .PAD_VALUE(BPAD)) dut_b (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .enable(enable_b),
    .s_axis_tvalid(sb_tvalid), .s_axis_tready(sb_tready), .s_axis_tdata(sb_tdata),
    .s_axis_tuser(sb_tuser), .s_axis_tlast(sb_tlast),
    .m_axis_tvalid(mb_tvalid), .m_axis_tready(mb_tready), .m_axis_tdata(mb_tdata),
    .m_axis_tuser(mb_tuser), .m_axis_tlast(mb_tlast), .m_axis_tkeep(mb_tkeep));

  int n_chk = 0, n_pass = 0;
  int cyc = 0, n_in_acc = 0;
  logic [7:0] px [256];
  beat_t src_q[$], srcb_q[$], out_q[$], outb_q[$], byp_ref[$];
  int out_t[$];
  logic s_acc = 1'b0, sb_acc = 1'b0;
  logic gap_en = 1'b0, rdy_rand = 1'b0;
  logic stall_prev = 1'b0;
  logic [9:0] stall_val = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Expected beat at output position (r,c): border outside the interior window,
  // otherwise the interior pixel at the matching offset.
  function automatic beat_t exp_beat(input int sel, input int r, input int c, input int base);
    int w, h, pc, pr, iw;
    logic [7:0] pad;
    beat_t bt;
    if (sel == 0) begin w = AW; h = AH; pc = APC; pr = APR; pad = APAD; end
    else begin w = BW; h = BH; pc = BPC; pr = BPR; pad = BPAD; end
    iw = w - 2 * pc;
    bt = '0;
    bt.u = (r == 0 && c == 0);
    bt.l = (c == w - 1);
    if (r >= pr && r < h - pr && c >= pc && c < w - pc) bt.d = px[base + (r - pr) * iw + (c - pc)];
    else bt.d = pad;
    return bt;
  endfunction

  always @(negedge clk) begin
    cyc++;
    s_acc  = rst_n && s_tvalid && s_tready;
    sb_acc = rst_n && sb_tvalid && sb_tready;
    if (s_acc) n_in_acc++;
    if (rst_n && m_tvalid && m_tready) begin
      out_q.push_back('{d: m_tdata, u: m_tuser, l: m_tlast, b: 1'b0});
      out_t.push_back(cyc);
    end
    if (rst_n && mb_tvalid && mb_tready)
      outb_q.push_back('{d: mb_tdata, u: mb_tuser, l: mb_tlast, b: 1'b0});
    if (rst_n && stall_prev)
      chk("stall_hold", 32'({m_tvalid, m_tuser, m_tlast, m_tdata}), 32'({1'b1, stall_val}));
    stall_prev = rst_n && m_tvalid && !m_tready;
    stall_val  = {m_tuser, m_tlast, m_tdata};
    if (rst_n && s_tvalid && s_tbyp && !s_tuser)
      chk("bypass_passthru", 32'({m_tvalid, m_tdata, m_tlast, s_tready}),
          32'({1'b1, s_tdata, s_tlast, m_tready}));
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      s_tvalid  = 1'b0;
      sb_tvalid = 1'b0;
    end else begin
      if (s_acc) begin src_q.delete(0); s_tvalid = 1'b0; end
      if (!s_tvalid && src_q.size() > 0 && (!gap_en || $urandom_range(1, 0) == 1)) begin
        s_tvalid = 1'b1;
        {s_tdata, s_tuser, s_tlast, s_tbyp} = src_q[0];
      end
      m_tready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
      if (sb_acc) begin srcb_q.delete(0); sb_tvalid = 1'b0; end
      if (!sb_tvalid && srcb_q.size() > 0) begin
        sb_tvalid = 1'b1;
        {sb_tdata, sb_tuser, sb_tlast} = {srcb_q[0].d, srcb_q[0].u, srcb_q[0].l};
      end
    end
  end

  task automatic push_frame(input int sel, input int base);
    beat_t bt;
    for (int k = 0; k < 8; k++) begin
      bt = '{d: px[base + k], u: (k == 0), l: (k % 4 == 3), b: 1'b0};
      if (sel == 0) src_q.push_back(bt);
      else srcb_q.push_back(bt);
    end
  endtask

  task automatic wait_out(input int sel, input int n, input int budget, input int settle);
    int t;
    t = 0;
    while (((sel == 0) ? out_q.size() : outb_q.size()) < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t >= budget) $display("FAIL wait_out: got %0d beats required %0d", (sel == 0) ? out_q.size() : outb_q.size(), n);
    repeat (settle) @(negedge clk);
  endtask

  task automatic cmp_pad(input int sel, input string tag, input int start, input int base);
    int w, h, idx;
    beat_t o;
    w = (sel == 0) ? AW : BW;
    h = (sel == 0) ? AH : BH;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        idx = start + r * w + c;
        if (sel == 0) o = (idx < out_q.size()) ? out_q[idx] : '1;
        else o = (idx < outb_q.size()) ? outb_q[idx] : '1;
        chk($sformatf("%s_r%0dc%0d", tag, r, c), 32'(o), 32'(exp_beat(sel, r, c, base)));
      end
  endtask

  task automatic clear_a();
    out_q.delete();
    out_t.delete();
    n_in_acc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    beat_t bt;
    rst_n = 1'b1; enable = 1'b1; enable_b = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0; s_tbyp = 1'b0;
    sb_tvalid = 1'b0; sb_tdata = '0; sb_tuser = 1'b0; sb_tlast = 1'b0;
    m_tready = 1'b1; mb_tready = 1'b1;
    #3 rst_n = 1'b0;
    #9;
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_tuser_tlast", 32'({m_tuser, m_tlast}), 32'd0);
    chk("rst_tkeep", 32'(m_tkeep), 32'd1);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_b_tvalid", 32'(mb_tvalid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed frame: pixels 1..8, downstream always ready.
    for (int k = 0; k < 8; k++) px[k] = 8'(k + 1);
    push_frame(0, 0);
    wait_out(0, 24, 300, 6);
    chk("t1_count", out_q.size(), 24);
    cmp_pad(0, "t1", 0, 0);
    chk("t1_no_bubbles", (out_q.size() == 24) ? out_t[23] - out_t[0] : -1, 23);
    chk("t1_in_accepted", n_in_acc, 8);
    clear_a();

    // Two random frames with random downstream stalls and input gaps.
    for (int k = 0; k < 16; k++) px[k] = 8'($urandom);
    gap_en = 1'b1; rdy_rand = 1'b1;
    push_frame(0, 0);
    push_frame(0, 8);
    wait_out(0, 48, 2000, 6);
    chk("t2_count", out_q.size(), 48);
    cmp_pad(0, "t2f0", 0, 0);
    cmp_pad(0, "t2f1", 24, 8);
    chk("t2_in_accepted", n_in_acc, 16);
    gap_en = 1'b0; rdy_rand = 1'b0;
    repeat (4) @(negedge clk);
    clear_a();

    // Stray beats before start-of-frame are consumed and dropped.
    for (int k = 0; k < 3; k++) src_q.push_back('{d: 8'($urandom), u: 1'b0, l: 1'b0, b: 1'b0});
    for (int k = 16; k < 24; k++) px[k] = 8'($urandom);
    push_frame(0, 16);
    wait_out(0, 24, 400, 6);
    chk("t3_count", out_q.size(), 24);
    cmp_pad(0, "t3", 0, 16);
    chk("t3_in_accepted", n_in_acc, 11);
    clear_a();

    // Reset mid-body, then a fresh frame.
    for (int k = 24; k < 40; k++) px[k] = 8'($urandom);
    push_frame(0, 24);
    wait_out(0, 9, 300, 0);
    #1;
    chk("t4_pre_rst_tvalid", 32'(m_tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_tvalid", 32'(m_tvalid), 32'd0);
    src_q.delete();
    s_tvalid = 1'b0;
    clear_a();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_frame(0, 32);
    wait_out(0, 24, 400, 6);
    chk("t4_count", out_q.size(), 24);
    cmp_pad(0, "t4", 0, 32);
    clear_a();

    // Bypass frame, enable raised mid-frame, then a padded frame.
    enable = 1'b0;
    rdy_rand = 1'b1;
    for (int k = 40; k < 72; k++) px[k] = 8'($urandom);
    for (int k = 0; k < 24; k++) begin
      bt = '{d: px[40 + k], u: (k == 0), l: (k % 6 == 5), b: 1'b1};
      src_q.push_back(bt);
      byp_ref.push_back(bt);
    end
    push_frame(0, 64);
    wait_out(0, 10, 400, 0);
    enable = 1'b1;
    wait_out(0, 48, 2000, 6);
    chk("t5_count", out_q.size(), 48);
    for (int i = 0; i < 24; i++) begin
      bt = byp_ref[i];
      bt.b = 1'b0;
      chk($sformatf("t5_byp%0d", i), 32'((i < out_q.size()) ? out_q[i] : '1), 32'(bt));
    end
    cmp_pad(0, "t5pad", 24, 64);
    rdy_rand = 1'b0;

    // No border rows, two border columns on each side.
    for (int k = 80; k < 88; k++) px[k] = 8'($urandom);
    push_frame(1, 80);
    wait_out(1, 16, 300, 6);
    chk("t6_count", outb_q.size(), 16);
    cmp_pad(1, "t6", 0, 80);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
